// File: rtl/postbox_host_tx.sv
// Host end of the POST-box link: emits testreq pulse groups (raw counts or bit-serial bytes) and
// captures testack per group. Define TESTACK_SYNC_EN to sample testack through a 2-flop synchroniser.
module postbox_host_tx #(
  parameter int PWID_CYC  = 6,
  parameter int PGAP_CYC  = 6,
  parameter int BREAK_CYC = 300,
  parameter int TMR_W     = 9
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_mode,
  input  logic [3:0] cmd_count,
  input  logic [7:0] cmd_byte,
  output logic       testreq,
  input  logic       testack,
  output logic       busy,
  output logic       done,
  output logic       last_ack,
  output logic [7:0] rx_byte
);

  typedef enum logic [2:0] {S_IDLE, S_HIGH, S_GAP, S_BREAK, S_DONE} state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [3:0]       r_pulses;
  logic [6:0]       r_shreg;
  logic [2:0]       r_bits_left;
  logic             r_mode;
  logic             r_testreq;
  logic             r_cmd_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_last_ack;
  logic [7:0]       r_rx_byte;

  logic w_samp;
  logic w_final;
  logic w_ack;

`ifdef TESTACK_SYNC_EN
  logic [1:0] r_sync;
  logic       r_samp_pend;
  logic       r_samp_final;

  // The synchronised ack of a pulse is taken in the 2nd cycle of the following GAP/BREAK.
  assign w_samp  = r_samp_pend &&
                   (((r_state == S_GAP)   && (r_tmr == TMR_W'(PGAP_CYC - 2))) ||
                    ((r_state == S_BREAK) && (r_tmr == TMR_W'(BREAK_CYC - 2))));
  assign w_final = r_samp_final;
  assign w_ack   = r_sync[1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync       <= 2'b00;
      r_samp_pend  <= 1'b0;
      r_samp_final <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], testack};
      if ((r_state == S_HIGH) && (r_tmr == '0)) begin
        r_samp_pend  <= 1'b1;
        r_samp_final <= (r_pulses == 4'd1);
      end else if (w_samp) begin
        r_samp_pend <= 1'b0;
      end
    end
  end
`else
  assign w_samp  = (r_state == S_HIGH) && (r_tmr == '0);
  assign w_final = (r_pulses == 4'd1);
  assign w_ack   = testack;
`endif

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_pulses    <= 4'd0;
      r_shreg     <= 7'd0;
      r_bits_left <= 3'd0;
      r_mode      <= 1'b0;
      r_testreq   <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_last_ack  <= 1'b0;
      r_rx_byte   <= 8'h00;
    end else begin
      if (w_samp && w_final) begin
        r_last_ack <= w_ack;
        if (r_mode)
          r_rx_byte <= {r_rx_byte[6:0], w_ack};
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_mode      <= cmd_mode;
            r_shreg     <= cmd_byte[6:0];
            r_bits_left <= 3'd7;
            r_busy      <= 1'b1;
            r_cmd_ready <= 1'b0;
            if (!cmd_mode && (cmd_count == 4'd0)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_HIGH;
              r_testreq <= 1'b1;
              r_tmr     <= TMR_W'(PWID_CYC - 1);
              r_pulses  <= cmd_mode ? (cmd_byte[7] ? 4'd2 : 4'd1) : cmd_count;
            end
          end
        end
        S_HIGH: begin
          if (r_tmr == '0) begin
            r_testreq <= 1'b0;
            if (r_pulses == 4'd1) begin
              r_state <= S_BREAK;
              r_tmr   <= TMR_W'(BREAK_CYC - 1);
            end else begin
              r_state  <= S_GAP;
              r_tmr    <= TMR_W'(PGAP_CYC - 1);
              r_pulses <= r_pulses - 4'd1;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_GAP: begin
          if (r_tmr == '0) begin
            r_state   <= S_HIGH;
            r_testreq <= 1'b1;
            r_tmr     <= TMR_W'(PWID_CYC - 1);
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_BREAK: begin
          if (r_tmr == '0) begin
            // Byte mode: r_shreg[6] holds the next bit to send, MSB first.
            if (r_mode && (r_bits_left != 3'd0)) begin
              r_shreg     <= {r_shreg[5:0], 1'b0};
              r_bits_left <= r_bits_left - 3'd1;
              r_pulses    <= r_shreg[6] ? 4'd2 : 4'd1;
              r_state     <= S_HIGH;
              r_testreq   <= 1'b1;
              r_tmr       <= TMR_W'(PWID_CYC - 1);
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign testreq   = r_testreq;
  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign last_ack  = r_last_ack;
  assign rx_byte   = r_rx_byte;

endmodule

// File: tb/tb_postbox_host_tx.sv
// Randomised bench for postbox_host_tx: builds the expected testreq waveform and ack results
// from the pulse-group rules and plays the adapter by driving testack per pulse.
module tb_postbox_host_tx;
  localparam int PW = 6;
  localparam int PG = 6;
  localparam int BK = 300;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_mode = 1'b0;
  logic [3:0] cmd_count = 4'd0;
  logic [7:0] cmd_byte = 8'd0;
  logic       testack = 1'b0;
  logic       cmd_ready, testreq, busy, done, last_ack;
  logic [7:0] rx_byte;

  int n_checks = 0;
  int n_errors = 0;
  int last_wait = 0;

  logic       m_last_ack = 1'b0;
  logic [7:0] m_rx = 8'h00;

  postbox_host_tx #(.PWID_CYC(PW), .PGAP_CYC(PG), .BREAK_CYC(BK), .TMR_W(9)) dut (
    .refclk(refclk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_count(cmd_count), .cmd_byte(cmd_byte), .testreq(testreq),
    .testack(testack), .busy(busy), .done(done), .last_ack(last_ack), .rx_byte(rx_byte)
  );

  always #5 refclk = ~refclk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one command starting from a falling edge and follows it to the cycle after done.
  task automatic run_cmd(input logic mode, input logic [3:0] cnt, input logic [7:0] byt,
                         input logic [31:0] acks, input bit hold, input string name);
    bit         wave[$];
    int         pidx[$];
    int         groups[$];
    int         fin[$];
    int         p, waited, done_at, done_n, wave_err, len;
    bit         exp_req;
    logic       exp_last;
    logic [7:0] exp_rx;

    if (mode) begin
      for (int b = 7; b >= 0; b--) groups.push_back(byt[b] ? 2 : 1);
    end else if (cnt != 0) begin
      groups.push_back(int'(cnt));
    end
    p = 0;
    foreach (groups[g]) begin
      for (int j = 0; j < groups[g]; j++) begin
        repeat (PW) begin wave.push_back(1'b1); pidx.push_back(p); end
        if (j == groups[g] - 1) fin.push_back(p);
        p++;
        if (j < groups[g] - 1)
          repeat (PG) begin wave.push_back(1'b0); pidx.push_back(-1); end
      end
      repeat (BK) begin wave.push_back(1'b0); pidx.push_back(-1); end
    end
    exp_last = m_last_ack;
    exp_rx   = m_rx;
    foreach (fin[k]) begin
      exp_last = acks[fin[k]];
      if (mode) exp_rx = {exp_rx[6:0], acks[fin[k]]};
    end
    len = wave.size();

    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge refclk);
      waited++;
    end
    last_wait = waited;
    check_val({name, " ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_count = cnt;
    cmd_byte  = byt;
    @(posedge refclk);
    #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_mode  = 1'($urandom);
      cmd_count = 4'($urandom);
      cmd_byte  = 8'($urandom);
    end

    wave_err = 0;
    done_at  = -1;
    done_n   = 0;
    for (int i = 1; i <= len + 1; i++) begin
      @(negedge refclk);
      exp_req = (i <= len) ? wave[i-1] : 1'b0;
      if (testreq !== exp_req) wave_err++;
      if (busy !== 1'b1) wave_err++;
      if (done === 1'b1) begin
        done_n++;
        done_at = i;
      end
      testack = (i <= len && pidx[i-1] >= 0) ? acks[pidx[i-1]] : 1'b0;
    end
    @(negedge refclk);
    testack = 1'b0;
    if (done === 1'b1) done_n++;

    check_val({name, " wave_errors"}, wave_err, 0);
    check_val({name, " done_cycle"}, done_at, len + 1);
    check_val({name, " done_pulses"}, done_n, 1);
    check_val({name, " last_ack"}, last_ack, exp_last);
    check_val({name, " rx_byte"}, rx_byte, exp_rx);
    check_val({name, " ready_after"}, cmd_ready, 1);
    check_val({name, " busy_after"}, busy, 0);
    m_last_ack = exp_last;
    m_rx       = exp_rx;
    $display("cmd %s mode=%0d count=%0d byte=%02h acks=%08h done@T+%0d last_ack=%0d rx=%02h",
             name, mode, cnt, byt, acks, done_at, last_ack, rx_byte);
  endtask

  initial begin
    int   dn;
    logic rm;

    repeat (3) @(negedge refclk);
    check_val("reset testreq", testreq, 0);
    check_val("reset cmd_ready", cmd_ready, 1);
    check_val("reset busy", busy, 0);
    check_val("reset done", done, 0);
    check_val("reset last_ack", last_ack, 0);
    check_val("reset rx_byte", rx_byte, 8'h00);
    rst_n = 1'b1;
    @(negedge refclk);

    run_cmd(1'b0, 4'd4, 8'h00, 32'h0, 1'b0, "n4_noack");
    run_cmd(1'b0, 4'd3, 8'h00, 32'h4, 1'b0, "n3_ack3");
    run_cmd(1'b1, 4'd0, 8'hA8, 32'h92, 1'b0, "byte_a8");
    check_val("byte_a8 rx_const", rx_byte, 8'hA8);
    run_cmd(1'b0, 4'd0, 8'h00, 32'h0, 1'b0, "n0");

    // Reset during the 2nd HIGH of a 14-pulse train.
    cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_count = 4'd14;
    @(posedge refclk);
    #1;
    cmd_valid = 1'b0;
    repeat (15) @(negedge refclk);
    check_val("rst_mid pre_testreq", testreq, 1);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid testreq", testreq, 0);
    check_val("rst_mid cmd_ready", cmd_ready, 1);
    check_val("rst_mid busy", busy, 0);
    dn = 0;
    repeat (4) begin
      @(negedge refclk);
      if (done !== 1'b0) dn++;
    end
    rst_n = 1'b1;
    m_last_ack = 1'b0;
    m_rx = 8'h00;
    repeat (3) begin
      @(negedge refclk);
      if (done !== 1'b0) dn++;
    end
    check_val("rst_mid no_done", dn, 0);
    $display("cmd rst_mid reset during 2nd HIGH of N=14");
    run_cmd(1'b0, 4'd4, 8'h00, 32'h0, 1'b0, "n4_after_rst");

    run_cmd(1'b0, 4'd2, 8'h00, 32'h2, 1'b1, "held_1");
    run_cmd(1'b0, 4'd2, 8'h00, 32'h1, 1'b0, "held_2");
    check_val("held_2 accept_gap", last_wait, 0);

    for (int k = 0; k < 12; k++) begin
      rm = ($urandom_range(0, 2) == 0);
      run_cmd(rm, 4'($urandom), 8'($urandom), $urandom, 1'b0, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
